// File: rtl/dsp_chain_pkg.sv
// dsp_chain_pkg: shared widths, tag and FSM types for the DSP chain scheduler
package dsp_chain_pkg;
  localparam int AX_W   = 18;
  localparam int AY_W   = 19;
  localparam int RES_W  = 37;
  localparam int MODE_W = 11;
  typedef struct packed {
    logic v;
    logic last;
  } tag_t;
  typedef enum logic {COLLECT, ISSUE} state_t;
endpackage

// File: rtl/sop_result_fifo.sv
// sop_result_fifo: first-word-fall-through result FIFO with occupancy count
module sop_result_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  // storage is not reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  // pointers and occupancy; push+pop together leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign valid_o = cnt_q != '0;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/dsp_chain_sop_sched.sv
// dsp_chain_sop_sched: packs operand tuples into chain issues and accumulates per-vector dot-products
module dsp_chain_sop_sched
  import dsp_chain_pkg::*;
#(
  parameter int N_STAGES  = 3,
  parameter int CHAIN_LAT = 4,
  parameter int ACC_W     = 48,
  parameter int OUT_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [AX_W-1:0]            in_ax_i,
  input  logic [AY_W-1:0]            in_ay_i,
  input  logic [AX_W-1:0]            in_bx_i,
  input  logic [AY_W-1:0]            in_by_i,
  input  logic                       in_last_i,
  output logic [AX_W*N_STAGES-1:0]   dsp_ax_o,
  output logic [AY_W*N_STAGES-1:0]   dsp_ay_o,
  output logic [AX_W*N_STAGES-1:0]   dsp_bx_o,
  output logic [AY_W*N_STAGES-1:0]   dsp_by_o,
  output logic [MODE_W-1:0]          dsp_mode_o,
  input  logic [RES_W-1:0]           dsp_result_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ACC_W-1:0]           out_data_o,
  output logic                       busy_o
);
  localparam int SLOT_W = $clog2(N_STAGES + 1);
  localparam int CNT_W  = $clog2(OUT_DEPTH) + 1;
  localparam int OWE_W  = 8;
  state_t                          state_q, state_d;
  logic [SLOT_W-1:0]               slot_q, slot_d;
  logic                            last_q, last_d;
  logic [N_STAGES-1:0][AX_W-1:0]   ax_q, ax_d, bx_q, bx_d;
  logic [N_STAGES-1:0][AY_W-1:0]   ay_q, ay_d, by_q, by_d;
  tag_t                            pipe_q [CHAIN_LAT];
  tag_t                            tail;
  logic [ACC_W-1:0]                acc_q, acc_d, acc_sum;
  logic                            pend_q, pend_d;
  logic [CNT_W-1:0]                fifo_cnt;
  logic [OWE_W-1:0]                owed;
  logic                            pipe_any, credit_ok, issue, push, pop;
  // FIFO slots already promised: stored results plus last-tagged groups still in the chain
  always_comb begin
    owed     = OWE_W'(fifo_cnt);
    pipe_any = 1'b0;
    for (int i = 0; i < CHAIN_LAT; i++) begin
      owed     = owed + OWE_W'(pipe_q[i].v & pipe_q[i].last);
      pipe_any = pipe_any | pipe_q[i].v;
    end
  end
  assign credit_ok = owed + OWE_W'(last_q) < OWE_W'(OUT_DEPTH + 1);
  // collect tuples into staging slots, then issue the group once credit allows
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    last_d  = last_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    bx_d    = bx_q;
    by_d    = by_q;
    issue   = 1'b0;
    if (state_q == COLLECT) begin
      if (in_valid_i) begin
        ax_d[slot_q] = in_ax_i;
        ay_d[slot_q] = in_ay_i;
        bx_d[slot_q] = in_bx_i;
        by_d[slot_q] = in_by_i;
        last_d       = in_last_i;
        if (slot_q == SLOT_W'(N_STAGES - 1) || in_last_i) state_d = ISSUE;
        else slot_d = slot_q + 1'b1;
      end
    end else if (credit_ok) begin
      issue   = 1'b1;
      ax_d    = '0;
      ay_d    = '0;
      bx_d    = '0;
      by_d    = '0;
      slot_d  = '0;
      last_d  = 1'b0;
      state_d = COLLECT;
    end
  end
  assign in_ready_o = state_q == COLLECT;
  assign dsp_ax_o   = issue ? ax_q : '0;
  assign dsp_ay_o   = issue ? ay_q : '0;
  assign dsp_bx_o   = issue ? bx_q : '0;
  assign dsp_by_o   = issue ? by_q : '0;
  assign dsp_mode_o = '0;
  assign tail    = pipe_q[CHAIN_LAT-1];
  assign acc_sum = acc_q + {{(ACC_W-RES_W){dsp_result_i[RES_W-1]}}, dsp_result_i};
  // fold returning chain results into the accumulator; a last group hands the sum to the FIFO
  always_comb begin
    acc_d  = tail.v ? (tail.last ? '0 : acc_sum) : acc_q;
    pend_d = tail.v ? !tail.last : pend_q;
    push   = tail.v & tail.last;
  end
  // state, staging, tag pipe and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      slot_q  <= '0;
      last_q  <= 1'b0;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      acc_q   <= '0;
      pend_q  <= 1'b0;
      for (int i = 0; i < CHAIN_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      last_q    <= last_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      acc_q     <= acc_d;
      pend_q    <= pend_d;
      pipe_q[0] <= '{v: issue, last: issue & last_q};
      for (int i = 1; i < CHAIN_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign pop    = out_valid_o & out_ready_i;
  assign busy_o = state_q != COLLECT || slot_q != '0 || pipe_any || acc_q != '0 || pend_q;
  sop_result_fifo #(.W(ACC_W), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (acc_sum),
    .pop_i   (pop),
    .data_o  (out_data_o),
    .valid_o (out_valid_o),
    .count_o (fifo_cnt)
  );
endmodule
